// File: rtl/pwm_spi_pkg.sv
// Shared widths and FSM encoding for the SPI-to-register-file bridge.
package pwm_spi_pkg;

   localparam int SPI_ADDR_W = 6;
   localparam int SPI_DATA_W = 8;
   localparam int SPI_RW_BIT = 7;

   typedef enum logic [2:0] {
      IDLE,
      INSTR,
      RD_REQ,
      RD_WAIT,
      DATA,
      DONE
   } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one async input plus registered rise/fall pulses.
// Edge pulse appears SYNC_STAGES+1 clk after the pin edge; no backpressure.
module spi_sync_edge #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev;

   assign dout = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= {SYNC_STAGES{RST_VAL}};
         prev   <= RST_VAL;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         sync_q <= SYNC_STAGES'({sync_q, din});
         prev   <= dout;
         rise   <= dout & ~prev;
         fall   <= ~dout & prev;
      end
   end

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave turning instruction+data frames into one-cycle read/write strobes.
// Strobes 1 clk after the relevant edge is detected; SPI_BURST_EN enables auto-increment bursts.
module spi_reg_bridge
   import pwm_spi_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sclk,
   input  logic                  cs_n,
   input  logic                  mosi,
   output logic                  miso,
   output logic                  read,
   output logic                  write,
   output logic [SPI_ADDR_W-1:0] addr,
   output logic [SPI_DATA_W-1:0] data_write,
   input  logic [SPI_DATA_W-1:0] data_read,
   output logic                  frame_err
);

   localparam int CNT_W = $clog2(SPI_DATA_W);

   logic sclk_s, sclk_rise, sclk_fall;
   logic cs_s, cs_rise, cs_fall;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                   mosi_s;
   logic [SYNC_STAGES+1:0] flush_sr;
   logic                   flushed;

   spi_state_t             state;
   logic [CNT_W-1:0]       bit_cnt;
   logic [SPI_DATA_W-2:0]  rx_sh;
   logic [SPI_DATA_W-2:0]  tx_sh;
   logic                   is_write;
   logic                   tx_armed;
   logic                   last_bit;
   logic [SPI_DATA_W-1:0]  rx_byte;
`ifdef SPI_BURST_EN
   logic                   bump;
`endif

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (sclk),
      .dout (sclk_s),
      .rise (sclk_rise),
      .fall (sclk_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (cs_n),
      .dout (cs_s),
      .rise (cs_rise),
      .fall (cs_fall)
   );

   assign mosi_s   = mosi_sync[SYNC_STAGES-1];
   assign flushed  = flush_sr[SYNC_STAGES+1];
   assign last_bit = (bit_cnt == CNT_W'(SPI_DATA_W - 1));
   assign rx_byte  = {rx_sh, mosi_s};

   always_ff @(posedge clk) begin
      if (rst) begin
         mosi_sync <= '0;
      end else begin
         mosi_sync <= SYNC_STAGES'({mosi_sync, mosi});
      end
   end

   // The cs_n synchroniser restarts at 1, so a cs_n held low across reset
   // produces a false falling edge; ignore edges until the chain has flushed.
   always_ff @(posedge clk) begin
      if (rst) begin
         flush_sr <= '0;
      end else begin
         flush_sr <= {flush_sr[SYNC_STAGES:0], 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         rx_sh      <= '0;
         tx_sh      <= '0;
         is_write   <= 1'b0;
         tx_armed   <= 1'b0;
         miso       <= 1'b0;
         read       <= 1'b0;
         write      <= 1'b0;
         addr       <= '0;
         data_write <= '0;
         frame_err  <= 1'b0;
`ifdef SPI_BURST_EN
         bump       <= 1'b0;
`endif
      end else begin
         read      <= 1'b0;
         write     <= 1'b0;
         frame_err <= 1'b0;
`ifdef SPI_BURST_EN
         // Write bursts advance the address only after the strobe cycle.
         bump <= 1'b0;
         if (bump) begin
            addr <= addr + 1'b1;
         end
`endif
         case (state)
            IDLE: begin
               if (cs_fall && flushed && !sclk_s) begin
                  state    <= INSTR;
                  bit_cnt  <= '0;
                  rx_sh    <= '0;
                  tx_sh    <= '0;
                  tx_armed <= 1'b0;
               end
            end

            INSTR: begin
               if (cs_rise) begin
                  state     <= IDLE;
                  frame_err <= (bit_cnt != '0);
               end else if (sclk_rise) begin
                  rx_sh   <= rx_byte[SPI_DATA_W-2:0];
                  bit_cnt <= bit_cnt + 1'b1;
                  if (last_bit) begin
                     addr     <= rx_byte[SPI_ADDR_W-1:0];
                     is_write <= rx_byte[SPI_RW_BIT];
                     if (rx_byte[SPI_RW_BIT]) begin
                        state <= DATA;
                     end else begin
                        read  <= 1'b1;
                        state <= RD_REQ;
                     end
                  end
               end
            end

            RD_REQ: begin
               state <= cs_s ? IDLE : RD_WAIT;
            end

            RD_WAIT: begin
               if (cs_s) begin
                  state <= IDLE;
               end else begin
                  miso     <= data_read[SPI_DATA_W-1];
                  tx_sh    <= data_read[SPI_DATA_W-2:0];
                  tx_armed <= 1'b0;
                  state    <= DATA;
               end
            end

            DATA: begin
               if (cs_rise) begin
                  state     <= IDLE;
                  miso      <= 1'b0;
                  frame_err <= (bit_cnt != '0);
               end else begin
                  // Only a falling edge after a data-bit rise advances MISO,
                  // so the instruction's last falling edge keeps bit 7 in place.
                  if (sclk_fall && tx_armed) begin
                     miso     <= tx_sh[SPI_DATA_W-2];
                     tx_sh    <= {tx_sh[SPI_DATA_W-3:0], 1'b0};
                     tx_armed <= 1'b0;
                  end
                  if (sclk_rise) begin
                     rx_sh    <= rx_byte[SPI_DATA_W-2:0];
                     bit_cnt  <= bit_cnt + 1'b1;
                     tx_armed <= !is_write;
                     if (last_bit) begin
                        if (is_write) begin
                           write      <= 1'b1;
                           data_write <= rx_byte;
                        end
`ifdef SPI_BURST_EN
                        if (is_write) begin
                           bump <= 1'b1;
                        end else begin
                           addr  <= addr + 1'b1;
                           read  <= 1'b1;
                           state <= RD_REQ;
                        end
`else
                        state    <= DONE;
                        miso     <= 1'b0;
                        tx_armed <= 1'b0;
`endif
                     end
                  end
               end
            end

            DONE: begin
               if (cs_s) begin
                  state <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed plus randomized frames against a frame-level model of the bridge.
module tb_spi_reg_bridge;

   logic       clk = 1'b0;
   logic       rst;
   logic       sclk;
   logic       cs_n;
   logic       mosi;
   logic       miso;
   logic       read;
   logic       write;
   logic [5:0] addr;
   logic [7:0] data_write;
   logic [7:0] data_read;
   logic       frame_err;

   always #5 clk = ~clk;

   spi_reg_bridge #(.SYNC_STAGES(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .sclk       (sclk),
      .cs_n       (cs_n),
      .mosi       (mosi),
      .miso       (miso),
      .read       (read),
      .write      (write),
      .addr       (addr),
      .data_write (data_write),
      .data_read  (data_read),
      .frame_err  (frame_err)
   );

   logic [7:0]  ref_mem [64];
   logic [15:0] ev_q [$];
   logic [7:0]  got_miso [4];
   int          total = 0;
   int          passed = 0;
   int          ferr_cnt = 0;
   int          both_cnt = 0;
   int          long_cnt = 0;
   logic        read_d = 1'b0;
   logic        write_d = 1'b0;

   // Register file: registered read data, one clk after the strobe.
   always @(posedge clk) begin
      if (read) data_read <= ref_mem[addr];
   end

   always @(negedge clk) begin
      if (read)  ev_q.push_back({2'b01, addr, 8'h00});
      if (write) ev_q.push_back({2'b10, addr, data_write});
      if (read && write) both_cnt++;
      if ((read && read_d) || (write && write_d)) long_cnt++;
      if (frame_err) ferr_cnt++;
      read_d  = read;
      write_d = write;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic spi_bits(input logic [7:0] v, input int hi, input int lo, input int h,
                           output logic [7:0] rxv);
      rxv = 8'h00;
      for (int i = hi; i >= lo; i--) begin
         mosi = v[i];
         wait_clk(h);
         rxv[i] = miso;
         sclk = 1'b1;
         wait_clk(h);
         sclk = 1'b0;
      end
   endtask

   task automatic send_frame(input logic [7:0] b [4], input int n, input int h);
      logic [7:0] r;
      cs_n = 1'b0;
      wait_clk(h);
      for (int k = 0; k < n; k++) begin
         spi_bits(b[k], 7, 0, h, r);
         got_miso[k] = r;
      end
      wait_clk(h);
      cs_n = 1'b1;
      mosi = 1'b0;
      wait_clk(12);
   endtask

   // Expected strobes and MISO bytes derived from the frame bytes alone.
   task automatic check_frame(input string name, input logic [7:0] b [4], input int n,
                              input int ferr_base);
      logic [15:0] exp_q [$];
      logic [7:0]  exp_miso [4];
      logic [5:0]  ak;
      int          nd;
      for (int k = 0; k < 4; k++) exp_miso[k] = 8'h00;
      nd = 0;
      if (n >= 2) begin
`ifdef SPI_BURST_EN
         nd = n - 1;
`else
         nd = 1;
`endif
      end
      for (int k = 0; k < nd; k++) begin
         ak = b[0][5:0] + 6'(k);
         if (b[0][7]) begin
            exp_q.push_back({2'b10, ak, b[k+1]});
         end else begin
            exp_q.push_back({2'b01, ak, 8'h00});
            exp_miso[k+1] = ref_mem[ak];
         end
      end
      check({name, " strobe count"}, ev_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++)
         check($sformatf("%s strobe%0d", name, i), ev_q[i], exp_q[i]);
      for (int k = 0; k < n; k++)
         check($sformatf("%s miso byte%0d", name, k), got_miso[k], exp_miso[k]);
      check({name, " frame_err"}, ferr_cnt - ferr_base, 0);
      for (int i = 0; i < exp_q.size(); i++)
         if (exp_q[i][15:14] == 2'b10) ref_mem[exp_q[i][13:8]] = exp_q[i][7:0];
      ev_q.delete();
   endtask

   task automatic check_idle_outputs(input string name);
      check({name, " miso"}, miso, 0);
      check({name, " read"}, read, 0);
      check({name, " write"}, write, 0);
      check({name, " addr"}, addr, 0);
      check({name, " data_write"}, data_write, 0);
      check({name, " frame_err"}, frame_err, 0);
   endtask

   initial begin
      logic [7:0] b [4];
      logic [7:0] r;
      int         base;
      int         n;
      int         h;

      rst  = 1'b1;
      sclk = 1'b0;
      cs_n = 1'b1;
      mosi = 1'b0;
      for (int i = 0; i < 64; i++) ref_mem[i] = 8'($urandom);
      ref_mem[6'h29] = 8'hA5;
      wait_clk(5);
      check_idle_outputs("reset");
      rst = 1'b0;
      wait_clk(10);

      // Single write
      b = '{8'h84, 8'h3C, 8'h00, 8'h00};
      base = ferr_cnt;
      send_frame(b, 2, 5);
      check_frame("write84", b, 2, base);
      check("write84 mem", ref_mem[6'h04], 8'h3C);

      // High-byte read at minimum SCLK timing
      b = '{8'h29, 8'h00, 8'h00, 8'h00};
      base = ferr_cnt;
      send_frame(b, 2, 4);
      check("read29 miso", got_miso[1], 8'hA5);
      check_frame("read29", b, 2, base);

      // Abort after 5 instruction bits
      base = ferr_cnt;
      cs_n = 1'b0;
      wait_clk(5);
      spi_bits(8'h81, 7, 3, 5, r);
      wait_clk(5);
      cs_n = 1'b1;
      mosi = 1'b0;
      wait_clk(12);
      check("abort strobes", ev_q.size(), 0);
      check("abort frame_err", ferr_cnt - base, 1);
      ev_q.delete();
      b = '{8'h81, 8'h01, 8'h00, 8'h00};
      base = ferr_cnt;
      send_frame(b, 2, 5);
      check_frame("after abort", b, 2, base);

      // Reset during data bit 3
      base = ferr_cnt;
      cs_n = 1'b0;
      wait_clk(5);
      spi_bits(8'h85, 7, 0, 5, r);
      spi_bits(8'h5A, 7, 5, 5, r);
      rst = 1'b1;
      wait_clk(1);
      rst = 1'b0;
      check_idle_outputs("mid reset");
      spi_bits(8'h5A, 4, 0, 5, r);
      wait_clk(5);
      cs_n = 1'b1;
      mosi = 1'b0;
      wait_clk(12);
      check("mid reset strobes", ev_q.size(), 0);
      check("mid reset frame_err", ferr_cnt - base, 0);
      ev_q.delete();
      b = '{8'h90, 8'h77, 8'h00, 8'h00};
      base = ferr_cnt;
      send_frame(b, 2, 6);
      check_frame("after reset", b, 2, base);

      // Burst frames (single byte only when bursts are disabled)
      b = '{8'hBF, 8'h11, 8'h22, 8'h00};
      base = ferr_cnt;
      send_frame(b, 3, 5);
      check_frame("burst write", b, 3, base);
      b = '{8'h3E, 8'h00, 8'h00, 8'h00};
      base = ferr_cnt;
      send_frame(b, 4, 4);
      check_frame("burst read", b, 4, base);

      for (int t = 0; t < 24; t++) begin
         for (int k = 0; k < 4; k++) b[k] = 8'($urandom);
         n = $urandom_range(2, 4);
         h = $urandom_range(4, 7);
         base = ferr_cnt;
         send_frame(b, n, h);
         check_frame($sformatf("rand%0d", t), b, n, base);
      end

      check("read+write overlap", both_cnt, 0);
      check("strobe width", long_cnt, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
